seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL provide port clk  input  1  rising-edge clock; the block uses only this clock.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL provide port start  input  1  request pulse; operands are sampled when start=1 and busy=0.
REQ-005 SHALL provide port dividend  input  WIDTH  numerator.
REQ-006 SHALL provide port divisor  input  WIDTH  denominator.
REQ-007 SHALL provide port busy  output  1  high while a division is in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse marking that results are valid.
REQ-009 SHALL provide port quotient  output  WIDTH  result quotient.
REQ-010 SHALL provide port remainder  output  WIDTH  result remainder.
REQ-011 SHALL provide port div_by_zero  output  1  flag set when the last accepted divisor was 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL hold busy=1 only in RUN, and done=1 only in DONE.
REQ-014 In IDLE or DONE, start=1 with divisor!=0 SHALL latch both operands, clear div_by_zero, load the iteration counter with WIDTH and enter RUN.
REQ-015 In IDLE or DONE, start=1 with divisor=0 SHALL enter DONE next cycle with quotient all ones, remainder=dividend and div_by_zero=1.
REQ-016 Each RUN cycle SHALL perform one restoring step: shift {rem,quo} left 1; trial = rem + ~divisor + 1; carry-out=1 keeps trial and sets quo LSB=1, else restores rem and sets quo LSB=0.
REQ-017 The trial subtract SHALL be WIDTH+1 bits wide so that no carry is lost.
REQ-018 RUN SHALL last exactly WIDTH cycles and then enter DONE, so done is asserted WIDTH+1 cycles after the start edge.
REQ-019 DONE SHALL last one cycle and then return to IDLE unless start is accepted in that cycle.
REQ-020 quotient, remainder and div_by_zero SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 Input changes while busy=1 SHALL NOT affect the result.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and the internal counter/registers to 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow deassertion.
REQ-025 The first start is accepted on the first rising clk edge after rst_n rises.

Configuration
REQ-026 Macro SEQ_DIVIDER_SIGNED_EN, when defined, SHALL add input port signed_op (1 bit, sampled with start).
REQ-027 With the macro and signed_op=1, the block SHALL divide magnitudes, negate the quotient when operand signs differ, and give the remainder the dividend's sign.
REQ-028 With the macro and signed_op=1, most-negative/-1 SHALL yield quotient=most-negative and remainder=0, with no flag.
REQ-029 Without the macro, the signed_op port SHALL NOT exist and all division SHALL be unsigned; latency is identical in both builds.

Verification
REQ-030 dividend=100, divisor=7, WIDTH=32 -> done exactly 33 cycles after start, quotient=14, remainder=2, div_by_zero=0.
REQ-031 dividend=0x1234, divisor=0 -> done on the next cycle, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-032 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-033 Second start with different operands at cycle 10 of RUN -> ignored, first result returned unchanged; start in the DONE cycle -> accepted, with back-to-back done pulses 33 cycles apart.
REQ-034 rst_n pulsed low at cycle 15 of RUN -> all outputs 0 immediately, no done pulse within 40 cycles after release.
REQ-035 (SEQ_DIVIDER_SIGNED_EN) signed_op=1, -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH cycles per division.
// Optional signed division is enabled by defining SEQ_DIVIDER_SIGNED_EN (adds port signed_op).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic             neg_quo_r;
  logic             neg_rem_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic             accept_s;
  logic             dsr_zero_s;
  logic             sop_s;
  logic             dvd_neg_s;
  logic             dsr_neg_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dsr_mag_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic             no_borrow_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] quo_fin_s;
  logic [WIDTH-1:0] rem_fin_s;
  logic             last_step_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sop_s = signed_op;
`else
  assign sop_s = 1'b0;
`endif

  assign accept_s    = start && (state_r != ST_RUN);
  assign dsr_zero_s  = (divisor == ZERO_W);
  assign last_step_s = (cnt_r == CNT_ONE);

  // Operand sign extraction and magnitude conversion at acceptance time
  always_comb begin
    dvd_neg_s = sop_s & dividend[WIDTH-1];
    dsr_neg_s = sop_s & divisor[WIDTH-1];
    dvd_mag_s = dividend;
    dsr_mag_s = divisor;
    if (dvd_neg_s) begin
      dvd_mag_s = ~dividend + ONE_W;
    end else begin
      dvd_mag_s = dividend;
    end
    if (dsr_neg_s) begin
      dsr_mag_s = ~divisor + ONE_W;
    end else begin
      dsr_mag_s = divisor;
    end
  end

  // One restoring step; the WIDTH+1-bit trial's MSB is the inverted carry-out
  always_comb begin
    rem_sh_s    = {rem_r, quo_r[WIDTH-1]};
    trial_s     = rem_sh_s + ~{1'b0, dsr_r} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow_s = ~trial_s[WIDTH];
    quo_next_s  = {quo_r[WIDTH-2:0], no_borrow_s};
    rem_next_s  = rem_sh_s[WIDTH-1:0];
    if (no_borrow_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = rem_sh_s[WIDTH-1:0];
    end
  end

  // Sign fix-up applied to the final step's result
  always_comb begin
    quo_fin_s = quo_next_s;
    rem_fin_s = rem_next_s;
    if (neg_quo_r) begin
      quo_fin_s = ~quo_next_s + ONE_W;
    end else begin
      quo_fin_s = quo_next_s;
    end
    if (neg_rem_r) begin
      rem_fin_s = ~rem_next_s + ONE_W;
    end else begin
      rem_fin_s = rem_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state_s = dsr_zero_s ? ST_DONE : ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_step_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      rem_r       <= ZERO_W;
      quo_r       <= ZERO_W;
      dsr_r       <= ZERO_W;
      neg_quo_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= ZERO_W;
      remainder_r <= ZERO_W;
      dbz_r       <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_RUN);
      done_r  <= (next_state_s == ST_DONE);
      if (accept_s) begin
        if (dsr_zero_s) begin
          quotient_r  <= ONES_W;
          remainder_r <= dividend;
          dbz_r       <= 1'b1;
          cnt_r       <= {CW{1'b0}};
        end else begin
          rem_r     <= ZERO_W;
          quo_r     <= dvd_mag_s;
          dsr_r     <= dsr_mag_s;
          neg_quo_r <= dvd_neg_s ^ dsr_neg_s;
          neg_rem_r <= dvd_neg_s;
          cnt_r     <= CNT_LOAD;
          dbz_r     <= 1'b0;
        end
      end else if (state_r == ST_RUN) begin
        rem_r <= rem_next_s;
        quo_r <= quo_next_s;
        cnt_r <= cnt_r - CNT_ONE;
        if (last_step_s) begin
          quotient_r  <= quo_fin_s;
          remainder_r <= rem_fin_s;
        end
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32); signed vectors run when
// SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int err_cnt;
  int chk_cnt;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Issues one start at the current negedge and returns cycles until done (capped at 100).
  task automatic do_div(input logic [31:0] dvd, input logic [31:0] dsr, input logic sop,
                        output int lat);
    dividend  = dvd;
    divisor   = dsr;
    signed_op = sop;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [31:0] q, input logic [31:0] r, input logic z);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_q"}, quotient, q);
    check_val({tag, "_r"}, remainder, r);
    check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, z});
  endtask

  initial begin
    int lat;
    int seen;
    err_cnt   = 0;
    chk_cnt   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    signed_op = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_q", quotient, 32'd0);
    check_val("rst_r", remainder, 32'd0);

    // first start on the first rising edge after reset release
    rst_n = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("run_busy", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_result("d100_7", lat, 33, 32'd14, 32'd2, 1'b0);
    check_val("done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_val("done_pulse", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("hold_q", quotient, 32'd14);

    do_div(32'h0000_1234, 32'd0, 1'b0, lat);
    check_result("dbz", lat, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    @(negedge clk);

    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    check_result("max_1", lat, 33, 32'hFFFF_FFFF, 32'd0, 1'b0);
    @(negedge clk);

    do_div(32'd5, 32'd9, 1'b0, lat);
    check_result("d5_9", lat, 33, 32'd0, 32'd5, 1'b0);
    @(negedge clk);

    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check_result("max_max", lat, 33, 32'd1, 32'd0, 1'b0);
    @(negedge clk);

    // start and operand changes while busy must not disturb the running division
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_result("ignore", lat, 33, 32'd333, 32'd1, 1'b0);
    @(negedge clk);

    // back-to-back: second start issued in the DONE cycle
    do_div(32'hDEAD_BEEF, 32'h0000_0010, 1'b0, lat);
    check_result("b2b_a", lat, 33, 32'h0DEA_DBEE, 32'h0000_000F, 1'b0);
    do_div(32'd12345678, 32'd1000, 1'b0, lat);
    check_result("b2b_b", lat, 33, 32'd12345, 32'd678, 1'b0);
    @(negedge clk);
    check_val("b2b_end", {31'd0, done}, 32'd0);

    // reset during RUN aborts and clears everything at once
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_q", quotient, 32'd0);
    check_val("arst_r", remainder, 32'd0);
    check_val("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check_val("no_done_after_rst", seen, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    check_result("s_m7_2", lat, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    check_result("s_min_m1", lat, 33, 32'h8000_0000, 32'd0, 1'b0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
